// File: rtl/mem_arb_pkg.sv
//==============================================================================
// Module      : mem_arb_pkg
// Description : State/grant encodings and default latencies for the
//               fetch/data memory port arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_IF_RD = 2'd1;
    localparam logic [1:0] c_D_RD  = 2'd2;
    localparam logic [1:0] c_D_WR  = 2'd3;

    localparam logic c_GNT_IF = 1'b0;
    localparam logic c_GNT_D  = 1'b1;

    localparam int c_READ_LAT  = 4;
    localparam int c_WRITE_LAT = 8;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_access_timer.sv
//==============================================================================
// Module      : access_timer
// Description : 4-bit access-cycle counter; load starts at 1, done flags
//               the final access cycle (count equals programmed latency).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module access_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_en,
    input  logic [3:0] i_lat,
    output logic       o_done
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= 4'd1;
        end else if (i_en) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_done = (r_cnt == i_lat);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin sharing of one multi-cycle memory between the
//               instruction-fetch port and the load/store data port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int READ_LAT  = c_READ_LAT,
    parameter int WRITE_LAT = c_WRITE_LAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          d_read,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam logic [3:0] c_RD_LAT = 4'(READ_LAT);
    localparam logic [3:0] c_WR_LAT = 4'(WRITE_LAT);

    logic [1:0]    r_state;
    logic          r_last_grant;
    logic          r_if_ack;
    logic          r_d_ack;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_mem_read;
    logic          r_mem_write;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wd;

    logic          w_if_elig;
    logic          w_d_elig;
    logic          w_grant;
    logic          w_grant_d;
    logic          w_busy;
    logic          w_done;
    logic [3:0]    w_lat;

    // A port whose ack is high this cycle is still showing the old request.
    assign w_if_elig = if_req & ~r_if_ack;
    assign w_d_elig  = (d_read | d_write) & ~r_d_ack;
    assign w_grant   = (r_state == c_IDLE) & (w_if_elig | w_d_elig);
    assign w_grant_d = w_d_elig & (~w_if_elig | (r_last_grant == c_GNT_IF));
    assign w_busy    = (r_state != c_IDLE);
    assign w_lat     = (r_state == c_D_WR) ? c_WR_LAT : c_RD_LAT;

    access_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_grant),
        .i_en   (w_busy & ~w_done),
        .i_lat  (w_lat),
        .o_done (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_last_grant <= c_GNT_D;
            r_if_ack     <= 1'b0;
            r_d_ack      <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wd     <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            if (r_state == c_IDLE) begin
                if (w_grant) begin
                    if (w_grant_d) begin
                        r_last_grant <= c_GNT_D;
                        r_mem_addr   <= d_addr;
                        r_mem_wd     <= d_wdata;
                        // Simultaneous read and write is treated as a write.
                        if (d_write) begin
                            r_state     <= c_D_WR;
                            r_mem_write <= 1'b1;
                        end else begin
                            r_state    <= c_D_RD;
                            r_mem_read <= 1'b1;
                        end
                    end else begin
                        r_last_grant <= c_GNT_IF;
                        r_mem_addr   <= if_addr;
                        r_state      <= c_IF_RD;
                        r_mem_read   <= 1'b1;
                    end
                end
            end else if (w_done) begin
                r_state     <= c_IDLE;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                if (r_state == c_IF_RD) begin
                    r_if_rdata <= mem_rd;
                    r_if_ack   <= 1'b1;
                end else if (r_state == c_D_RD) begin
                    r_d_rdata <= mem_rd;
                    r_d_ack   <= 1'b1;
                end else begin
                    r_d_ack <= 1'b1;
                end
            end
        end
    end

    assign if_stall  = if_req & ~r_if_ack;
    assign d_stall   = (d_read | d_write) & ~r_d_ack;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wd    = r_mem_wd;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a word memory model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .READ_LAT(4), .WRITE_LAT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // 1KB word memory; the bench preloads it through its own write port
    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_a = '0;
    logic [31:0] pre_d = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (mem_write) mem[mem_addr[9:2]] <= mem_wd;
    end
    assign mem_rd = mem[mem_addr[9:2]];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        int          len;
        int          gap;
    } burst_t;

    burst_t      bq[$];
    logic [31:0] iq[$];
    logic [31:0] dq[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: strobe bursts and acks are compared against the queues
    int          run_len = 0;
    int          idle_cnt = 0;
    int          run_gap = 0;
    bit          run_wr;
    logic [31:0] run_addr;
    logic [31:0] run_wd;
    burst_t      e;
    logic [31:0] ev;

    always @(negedge clk) begin
        if (rst) begin
            run_len  = 0;
            idle_cnt = 0;
        end else begin
            if (mem_read | mem_write) begin
                if (run_len == 0) begin
                    run_wr   = mem_write;
                    run_addr = mem_addr;
                    run_wd   = mem_wd;
                    run_gap  = idle_cnt;
                end
                run_len++;
            end else begin
                if (run_len > 0) begin
                    if (bq.size() == 0) begin
                        check32("unexpected_burst", run_addr, 32'hFFFF_FFFF);
                    end else begin
                        e = bq.pop_front();
                        check32("burst_is_write", 32'(run_wr), 32'(e.wr));
                        check32("burst_addr", run_addr, e.addr);
                        if (e.wr) check32("burst_wdata", run_wd, e.wd);
                        check32("burst_len", 32'(run_len), 32'(e.len));
                        if (e.gap >= 0) check32("burst_gap", 32'(run_gap), 32'(e.gap));
                    end
                    run_len  = 0;
                    idle_cnt = 0;
                end
                idle_cnt++;
            end
            if (if_req && !if_stall) begin
                if (iq.size() == 0) check32("unexpected_if_ack", if_rdata, 32'hFFFF_FFFF);
                else begin
                    ev = iq.pop_front();
                    check32("if_rdata", if_rdata, ev);
                end
            end
            if ((d_read | d_write) && !d_stall) begin
                if (dq.size() == 0) check32("unexpected_d_ack", d_rdata, 32'hFFFF_FFFF);
                else begin
                    ev = dq.pop_front();
                    check32("d_rdata", d_rdata, ev);
                end
            end
        end
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_a = a[9:2]; pre_d = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic push_burst(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                              input int len, input int gap);
        burst_t b;
        b.wr = wr; b.addr = a; b.wd = wd; b.len = len; b.gap = gap;
        bq.push_back(b);
    endtask

    // Returns the number of negedges from issue up to and including the ack cycle
    task automatic do_if(input logic [31:0] a, output int n);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = a;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n = i + 1;
            if (!if_stall) break;
        end
        check32("if_ack_timeout", 32'(if_stall), 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic do_d(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, output int n);
        @(posedge clk); #1;
        d_read = rd; d_write = wr; d_addr = a; d_wdata = wd;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n = i + 1;
            if (!d_stall) break;
        end
        check32("d_ack_timeout", 32'(d_stall), 32'd0);
        @(posedge clk); #1;
        d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    int n1, n2;

    initial begin
        preload(32'h10,  32'hDEADBEEF);
        preload(32'h100, 32'hA1A1A1A1);
        preload(32'h104, 32'hB2B2B2B2);
        preload(32'h108, 32'hC3C3C3C3);
        preload(32'h10C, 32'hD4D4D4D4);
        preload(32'h200, 32'hCAFEF00D);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check32("rst_if_rdata", if_rdata, 32'h0);
        check32("rst_d_rdata", d_rdata, 32'h0);
        check32("rst_strobes", {30'b0, mem_read, mem_write}, 32'h0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_mem_wd", mem_wd, 32'h0);

        // Single fetch: cycle-accurate strobe/stall timing
        push_burst(1'b0, 32'h10, 32'h0, 4, -1);
        iq.push_back(32'hDEADBEEF);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h10;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check32("t1_mem_read", 32'(mem_read), 32'((c >= 1 && c <= 4) ? 1 : 0));
            check32("t1_if_stall", 32'(if_stall), 32'((c <= 4) ? 1 : 0));
        end
        @(posedge clk); #1 if_req = 1'b0;

        // Write then read back
        push_burst(1'b1, 32'h20, 32'h12345678, 8, -1);
        dq.push_back(32'h0);
        do_d(1'b0, 1'b1, 32'h20, 32'h12345678, n1);
        check32("t2_write_ack_cycles", 32'(n1), 32'd10);
        push_burst(1'b0, 32'h20, 32'h0, 4, -1);
        dq.push_back(32'h12345678);
        do_d(1'b1, 1'b0, 32'h20, 32'h0, n1);
        check32("t2_read_ack_cycles", 32'(n1), 32'd6);

        // First tie after reset goes to fetch; data granted in fetch's ack cycle
        pulse_reset();
        push_burst(1'b0, 32'h100, 32'h0, 4, -1);
        push_burst(1'b0, 32'h104, 32'h0, 4, 1);
        iq.push_back(32'hA1A1A1A1);
        dq.push_back(32'hB2B2B2B2);
        fork
            do_if(32'h100, n1);
            do_d(1'b1, 1'b0, 32'h104, 32'h0, n2);
        join
        check32("t3_tie1_if_cycles", 32'(n1), 32'd6);
        check32("t3_tie1_d_cycles", 32'(n2), 32'd11);
        // Lone fetch leaves last grant on fetch, so the next tie favours data
        push_burst(1'b0, 32'h100, 32'h0, 4, -1);
        iq.push_back(32'hA1A1A1A1);
        do_if(32'h100, n1);
        push_burst(1'b0, 32'h10C, 32'h0, 4, -1);
        push_burst(1'b0, 32'h108, 32'h0, 4, 1);
        dq.push_back(32'hD4D4D4D4);
        iq.push_back(32'hC3C3C3C3);
        fork
            do_if(32'h108, n1);
            do_d(1'b1, 1'b0, 32'h10C, 32'h0, n2);
        join
        check32("t3_tie2_d_cycles", 32'(n2), 32'd6);
        check32("t3_tie2_if_cycles", 32'(n1), 32'd11);

        // Reset in access cycle 2 aborts; held request restarts a full read
        push_burst(1'b0, 32'h200, 32'h0, 4, 1);
        iq.push_back(32'hCAFEF00D);
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h200;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check32("t4_strobes_after_rst", {30'b0, mem_read, mem_write}, 32'h0);
        check32("t4_if_rdata_cleared", if_rdata, 32'h0);
        check32("t4_d_rdata_cleared", d_rdata, 32'h0);
        check32("t4_if_stall_no_ack", 32'(if_stall), 32'd1);
        n1 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n1 = i + 1;
            if (!if_stall) break;
        end
        check32("t4_restart_cycles", 32'(n1), 32'd5);
        @(posedge clk); #1 if_req = 1'b0;

        // Read+write together is a write; d_rdata keeps its value
        push_burst(1'b0, 32'h20, 32'h0, 4, -1);
        dq.push_back(32'h12345678);
        do_d(1'b1, 1'b0, 32'h20, 32'h0, n1);
        push_burst(1'b1, 32'h40, 32'h55AA55AA, 8, -1);
        dq.push_back(32'h12345678);
        do_d(1'b1, 1'b1, 32'h40, 32'h55AA55AA, n1);
        check32("t5_rw_ack_cycles", 32'(n1), 32'd10);
        push_burst(1'b0, 32'h40, 32'h0, 4, -1);
        dq.push_back(32'h55AA55AA);
        do_d(1'b1, 1'b0, 32'h40, 32'h0, n1);

        // Write request dropped mid-access still runs the full write
        push_burst(1'b1, 32'h44, 32'h0BADCAFE, 8, -1);
        @(posedge clk); #1;
        d_write = 1'b1; d_addr = 32'h44; d_wdata = 32'h0BADCAFE;
        repeat (3) @(posedge clk);
        #1 d_write = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check32("t5_drop_write_done", 32'(mem_write), 32'd0);
        push_burst(1'b0, 32'h44, 32'h0, 4, -1);
        dq.push_back(32'h0BADCAFE);
        do_d(1'b1, 1'b0, 32'h44, 32'h0, n1);

        repeat (4) @(negedge clk);
        check32("burst_queue_empty", 32'(bq.size()), 32'd0);
        check32("if_queue_empty", 32'(iq.size()), 32'd0);
        check32("d_queue_empty", 32'(dq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
